fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the fetch stage and decode. It captures each instruction-memory response together with the PC and PC+4 that fetch forwarded for it. Entries are held in a small FIFO and presented to decode through a valid/ready handshake. It back-pressures fetch through `pc_stall` and discards wrong-path instructions on a redirect flush.

## Interface
Parameters:
- `DEPTH`, default 2: number of entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `flush`  in  1  redirect taken (same signal as fetch `sel_next_pc`); empties queue
- `in_valid`  in  1  instruction-memory response valid
- `in_instr`  in  32  returned instruction word
- `in_pc`  in  XLEN  PC of returned instruction (fetch `pc_out`)
- `in_pc_pls4`  in  XLEN  PC+4 of returned instruction (fetch `pc_pls4_out`)
- `pc_stall`  out  1  to fetch: hold PC
- `out_valid`  out  1  head entry valid to decode
- `out_ready`  in  1  decode accepts head
- `out_instr`  out  32  head instruction
- `out_pc`  out  XLEN  head PC
- `out_pc_pls4`  out  XLEN  head PC+4
- `count`  out  $clog2(DEPTH+1)  occupied entries
- `overflow_err`  out  1  sticky: response arrived while full and not popping

## Operation
- Registers: storage array, `wr_ptr`/`rd_ptr` ($clog2(DEPTH) bits, natural wrap at DEPTH), `count`, `kill_next`, `overflow_err`. All reset to 0; all outputs 0 in reset.
- `push = in_valid & ~flush & ~kill_next & (count < DEPTH | pop)`.
- `pop = out_valid & out_ready & ~flush`.
- Push writes the entry at `wr_ptr` and increments it. Pop increments `rd_ptr`.
- `count` += push − pop. Simultaneous push and pop at full or empty is legal; count is unchanged.
- `out_valid = (count != 0)`. Outputs are driven combinationally from storage[`rd_ptr`]; storage contents are irrelevant when invalid.
- `pc_stall = (count >= DEPTH-1) & ~pop`. This reserves one slot for the response already in flight (1-cycle memory latency).
- Flush:
  - next cycle `count`=0 and pointers=0;
  - `in_valid` in the flush cycle is ignored;
  - `kill_next` is set for exactly one cycle, which drops the stale wrong-path response returning the cycle after the flush.
- Flush during `kill_next`: `kill_next` is re-armed.
- Overflow: `in_valid & ~flush & ~kill_next & count==DEPTH & ~pop` sets `overflow_err`. The response is dropped. The flag clears only on reset.

## Timing
- `in_valid` at edge N → `out_valid` high after edge N (visible in cycle N+1); 1-cycle latency.
- Pop and push take effect on the same edge; bypass from input to output is not supported.
- `pc_stall` is combinational from `count`, `out_valid`, `out_ready`; fetch sees it the same cycle.
- Reset mid-operation: all state clears immediately (asynchronous); `out_valid` and `pc_stall` drop to 0.

## Configuration
- `FETCHQ_MISALIGN_CHECK_EN` defined:
  - adds per-entry bit `misalign = (in_pc[1:0] != 2'b00)`;
  - adds output `out_misalign` (1 bit, reset 0) for the head entry, for decode to raise an instruction-address-misaligned exception.
- Undefined: no extra bit or port; behaviour is otherwise identical.

## Structure
- Entry typedef `fetch_entry_t` {instr[31:0], pc[XLEN-1:0], pc_pls4[XLEN-1:0], optional misalign} goes in `instructions_pkg`, next to XLEN.
- One sub-module is natural: `fetchq_ptr_ctrl`, which owns the pointers, count, full/empty, `kill_next`, and `pc_stall`. The top holds storage and the muxes.

## Test plan
- Reset then single `in_valid` (pc=0x0, instr=0x00000013) → next cycle `out_valid`=1, `out_pc`=0x0, `out_pc_pls4`=0x4, `count`=1.
- Back-to-back 3 responses with `out_ready`=0, DEPTH=2 → `pc_stall`=1 once count=1; third response (forced) → `overflow_err`=1, `count` stays 2.
- Full queue, `out_ready`=1 with simultaneous `in_valid` (pc=0x8) → `count` stays 2, head advances, order 0x0, 0x4, 0x8 preserved.
- `flush` with count=2 and `in_valid` in the next cycle (pc=0xC) → `count`=0, pc 0xC dropped, following response (pc=0x100) enqueued.
- Pointer wrap: 10 push/pop pairs with `out_ready`=1 → outputs in order, `count` ≤1, no overflow.
- With `FETCHQ_MISALIGN_CHECK_EN`: push pc=0x2 → `out_misalign`=1; pc=0x4 → 0.

Source files
------------

// File: rtl/instructions_pkg.sv
// Shared instruction-path types: XLEN and the fetch queue entry layout.
// FETCHQ_MISALIGN_CHECK_EN adds a per-entry misalign flag to fetch_entry_t.
package instructions_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_pls4;
`ifdef FETCHQ_MISALIGN_CHECK_EN
        logic            misalign;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetchq_ptr_ctrl.sv
// Fetch queue control: pointers, occupancy, wrong-path kill and fetch stall.
// Latency: push/pop take effect on the same edge; stall is combinational.
// Backpressure: pc_stall keeps one slot free for the in-flight memory response.
module fetchq_ptr_ctrl #(
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          o_push,
    output logic [PW-1:0] o_wr_ptr,
    output logic [PW-1:0] o_rd_ptr,
    output logic [CW-1:0] o_count,
    output logic          o_out_valid,
    output logic          o_pc_stall,
    output logic          o_overflow_err
);

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_kill_next;
    logic          r_overflow_err;

    logic w_pop;
    logic w_push;
    logic w_full;
    logic w_accept;

    assign w_full   = (r_count == DEPTH_C);
    assign w_pop    = (r_count != '0) & out_ready & ~flush;
    assign w_accept = in_valid & ~flush & ~r_kill_next;
    assign w_push   = w_accept & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_kill_next    <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            // The response already in flight during a redirect is wrong-path.
            r_kill_next <= flush;
            if (w_accept & w_full & ~w_pop)
                r_overflow_err <= 1'b1;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push & ~w_pop)
                    r_count <= r_count + 1'b1;
                else if (w_pop & ~w_push)
                    r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_push         = w_push;
    assign o_wr_ptr       = r_wr_ptr;
    assign o_rd_ptr       = r_rd_ptr;
    assign o_count        = r_count;
    assign o_out_valid    = (r_count != '0);
    assign o_pc_stall     = (r_count >= DEPTH_M1_C) & ~w_pop;
    assign o_overflow_err = r_overflow_err;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode; FETCHQ_MISALIGN_CHECK_EN adds out_misalign.
// Latency: 1 cycle from in_valid to out_valid; no input-to-output bypass.
// Backpressure: pc_stall holds fetch early; redirect flush empties the queue.
module fetch_queue
    import instructions_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_pc_pls4,
    output logic                       pc_stall,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_pls4,
`ifdef FETCHQ_MISALIGN_CHECK_EN
    output logic                       out_misalign,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  r_mem [DEPTH];
    fetch_entry_t  w_wr_entry;
    fetch_entry_t  w_head;
    logic          w_push;
    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;

    fetchq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_ptr_ctrl (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .o_push         (w_push),
        .o_wr_ptr       (w_wr_ptr),
        .o_rd_ptr       (w_rd_ptr),
        .o_count        (count),
        .o_out_valid    (out_valid),
        .o_pc_stall     (pc_stall),
        .o_overflow_err (overflow_err)
    );

    always_comb begin
        w_wr_entry         = '0;
        w_wr_entry.instr   = in_instr;
        w_wr_entry.pc      = in_pc;
        w_wr_entry.pc_pls4 = in_pc_pls4;
`ifdef FETCHQ_MISALIGN_CHECK_EN
        w_wr_entry.misalign = (in_pc[1:0] != 2'b00);
`endif
    end

    // Storage is reset so that the head outputs read as zero during reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= w_wr_entry;
        end
    end

    assign w_head      = r_mem[w_rd_ptr];
    assign out_instr   = w_head.instr;
    assign out_pc      = w_head.pc;
    assign out_pc_pls4 = w_head.pc_pls4;
`ifdef FETCHQ_MISALIGN_CHECK_EN
    assign out_misalign = w_head.misalign;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=2); covers FETCHQ_MISALIGN_CHECK_EN when defined.
module tb_fetch_queue;
    import instructions_pkg::*;

    logic            clk;
    logic            rstn;
    logic            flush;
    logic            in_valid;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_pc_pls4;
    logic            pc_stall;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_pls4;
    logic [1:0]      count;
    logic            overflow_err;
`ifdef FETCHQ_MISALIGN_CHECK_EN
    logic            out_misalign;
`endif

    int n_vec;
    int n_err;

    fetch_queue #(.DEPTH(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_pc_pls4   (in_pc_pls4),
        .pc_stall     (pc_stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_pls4  (out_pc_pls4),
`ifdef FETCHQ_MISALIGN_CHECK_EN
        .out_misalign (out_misalign),
`endif
        .count        (count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
        in_valid   = v;
        in_pc      = pc;
        in_pc_pls4 = pc + 32'd4;
        in_instr   = ins;
        out_ready  = rdy;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        drv(0, 32'h0, 32'h0, 0, 0);
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pc_stall", pc_stall, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow_err, 0);
        chk("rst_out_pc", out_pc, 0);
        tick();
        rstn = 1'b1;

        // single response, then fill to DEPTH with out_ready low
        drv(1, 32'h0, 32'h00000013, 0, 0); #1;
        chk("a_pc_stall", pc_stall, 0);
        chk("a_out_valid", out_valid, 0);
        tick();
        drv(1, 32'h4, 32'h00400093, 0, 0); #1;
        chk("b_out_valid", out_valid, 1);
        chk("b_out_pc", out_pc, 32'h0);
        chk("b_out_pc_pls4", out_pc_pls4, 32'h4);
        chk("b_out_instr", out_instr, 32'h00000013);
        chk("b_count", count, 1);
        chk("b_pc_stall", pc_stall, 1);
        tick();
        // forced third response while full
        drv(1, 32'h8, 32'h00800113, 0, 0); #1;
        chk("c_count", count, 2);
        chk("c_pc_stall", pc_stall, 1);
        chk("c_overflow", overflow_err, 0);
        tick();
        // full with pop and push together
        drv(1, 32'h8, 32'h00800113, 1, 0); #1;
        chk("d_overflow", overflow_err, 1);
        chk("d_count", count, 2);
        chk("d_out_pc", out_pc, 32'h0);
        chk("d_pc_stall", pc_stall, 0);
        tick();
        drv(0, 32'h0, 32'h0, 1, 0); #1;
        chk("e_count", count, 2);
        chk("e_out_pc", out_pc, 32'h4);
        tick();
        drv(1, 32'h10, 32'h01000193, 0, 0); #1;
        chk("f_count", count, 1);
        chk("f_out_pc", out_pc, 32'h8);
        chk("f_out_instr", out_instr, 32'h00800113);
        tick();
        // flush with count=2; in_valid in flush cycle ignored
        drv(1, 32'h20, 32'h0, 1, 1); #1;
        chk("g_count", count, 2);
        chk("g_pc_stall", pc_stall, 1);
        tick();
        drv(1, 32'hC, 32'h00C00213, 0, 0); #1;
        chk("h_count", count, 0);
        chk("h_out_valid", out_valid, 0);
        chk("h_pc_stall", pc_stall, 0);
        tick();
        drv(1, 32'h100, 32'h10000013, 0, 0); #1;
        chk("i_count_kill", count, 0);
        tick();
        // flush again, then flush during kill_next re-arms it
        drv(0, 32'h0, 32'h0, 0, 1); #1;
        chk("j_count", count, 1);
        chk("j_out_pc", out_pc, 32'h100);
        chk("j_out_pc_pls4", out_pc_pls4, 32'h104);
        tick();
        drv(1, 32'h180, 32'h0, 0, 1); #1;
        chk("k_count", count, 0);
        tick();
        drv(1, 32'h200, 32'h20000013, 0, 0); #1;
        chk("l_count", count, 0);
        tick();
        drv(1, 32'h300, 32'h30000013, 1, 0); #1;
        chk("m_count_rearm", count, 0);
        tick();
        drv(0, 32'h0, 32'h0, 1, 0); #1;
        chk("n_count", count, 1);
        chk("n_out_pc", out_pc, 32'h300);
        tick();

        // pointer wrap: 10 push/pop pairs
        for (int i = 0; i < 10; i++) begin
            drv(1, 32'h1000 + 32'(i) * 4, 32'h50000000 | 32'(i), 1, 0); #1;
            if (i == 0) begin
                chk("w_count0", count, 0);
            end else begin
                chk("w_count", count, 1);
                chk("w_out_pc", out_pc, 32'h1000 + 32'(i - 1) * 4);
                chk("w_out_instr", out_instr, 32'h50000000 | 32'(i - 1));
            end
            chk("w_pc_stall", pc_stall, 0);
            tick();
        end
        drv(0, 32'h0, 32'h0, 0, 0); #1;
        chk("w_end_count", count, 1);
        chk("w_end_out_pc", out_pc, 32'h1024);
        chk("w_end_pc_stall", pc_stall, 1);

        // asynchronous reset mid-operation
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_pc_stall", pc_stall, 0);
        chk("ar_count", count, 0);
        chk("ar_overflow", overflow_err, 0);
        chk("ar_out_pc", out_pc, 0);
        tick();
        rstn = 1'b1;
        tick();

`ifdef FETCHQ_MISALIGN_CHECK_EN
        drv(1, 32'h2, 32'h00000013, 0, 0); #1;
        chk("m_rst_misalign", out_misalign, 0);
        tick();
        drv(1, 32'h4, 32'h00000013, 1, 0); #1;
        chk("m_out_pc2", out_pc, 32'h2);
        chk("m_misalign1", out_misalign, 1);
        tick();
        drv(0, 32'h0, 32'h0, 1, 0); #1;
        chk("m_out_pc4", out_pc, 32'h4);
        chk("m_misalign0", out_misalign, 0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
